// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core.
//  - Instruction field bit positions for A- and C-instructions.
//  - ALU comp codes and jump codes for the common Hack mnemonics.
//  - Default reset PC.
//  - 16-bit helper functions (and16 / not16 / add16) the ALU is built from.
package hack_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 15'h0000;

  // Instruction field positions
  localparam int INST_TYPE_BIT = 15;
  localparam int A_BIT         = 12;
  localparam int ZX_BIT        = 11;
  localparam int NX_BIT        = 10;
  localparam int ZY_BIT        = 9;
  localparam int NY_BIT        = 8;
  localparam int F_BIT         = 7;
  localparam int NO_BIT        = 6;
  localparam int DEST_A_BIT    = 5;
  localparam int DEST_D_BIT    = 4;
  localparam int DEST_M_BIT    = 3;
  localparam int JLT_BIT       = 2;
  localparam int JEQ_BIT       = 1;
  localparam int JGT_BIT       = 0;

  // Comp codes (zx,nx,zy,ny,f,no)
  localparam logic [5:0] COMP_ZERO = 6'b101010;
  localparam logic [5:0] COMP_D    = 6'b001100;
  localparam logic [5:0] COMP_A    = 6'b110000;
  localparam logic [5:0] COMP_DPA  = 6'b000010;
  localparam logic [5:0] COMP_NEG1 = 6'b111010;

  // Jump codes (jlt,jeq,jgt)
  localparam logic [2:0] JMP = 3'b111;
  localparam logic [2:0] JGT = 3'b001;
  localparam logic [2:0] JLT = 3'b100;

  function automatic logic [DATA_W-1:0] and16(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return a & b;
  endfunction

  function automatic logic [DATA_W-1:0] not16(input logic [DATA_W-1:0] a);
    return ~a;
  endfunction

  // Modular 16-bit add; carry out is discarded.
  function automatic logic [DATA_W-1:0] add16(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU, purely combinational.
// Ports:
//  i_x, i_y        16-bit operands (x = D, y = A or M)
//  i_zx, i_nx      zero / invert x
//  i_zy, i_ny      zero / invert y
//  i_f             1: x+y, 0: x&y
//  i_no            invert result
//  o_out           16-bit result
//  o_zr            result is zero
//  o_ng            result is negative (bit 15)
module hack_alu
  import hack_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic              i_zx,
  input  logic              i_nx,
  input  logic              i_zy,
  input  logic              i_ny,
  input  logic              i_f,
  input  logic              i_no,
  output logic [DATA_W-1:0] o_out,
  output logic              o_zr,
  output logic              o_ng
);

  logic [DATA_W-1:0] w_x_z;
  logic [DATA_W-1:0] w_x_n;
  logic [DATA_W-1:0] w_y_z;
  logic [DATA_W-1:0] w_y_n;
  logic [DATA_W-1:0] w_fn;

  assign w_x_z = i_zx ? '0 : i_x;
  assign w_x_n = i_nx ? not16(w_x_z) : w_x_z;
  assign w_y_z = i_zy ? '0 : i_y;
  assign w_y_n = i_ny ? not16(w_y_z) : w_y_z;
  assign w_fn  = i_f  ? add16(w_x_n, w_y_n) : and16(w_x_n, w_y_n);
  assign o_out = i_no ? not16(w_fn) : w_fn;
  assign o_zr  = (o_out == '0);
  assign o_ng  = o_out[DATA_W-1];

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: executes one 16-bit instruction per clock.
// Holds A, D and PC; drives the ALU, data-memory write and address.
// Ports:
//  clk          clock, all state updates on posedge
//  reset        synchronous active-high reset
//  instruction  instruction fetched from ROM[pc]
//  inM          RAM[addressM] read data
//  outM         ALU result (combinational), valid when writeM=1
//  writeM       write outM to RAM[addressM] at this edge
//  addressM     A[14:0] as held before this edge
//  pc           address of next instruction fetch
module hack_cpu
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] inM,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [ADDR_W-1:0] r_pc;

  logic              w_is_c;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_zr;
  logic              w_ng;
  logic              w_jump;
  logic              w_load_a;
  logic              w_load_d;

  assign w_is_c = instruction[INST_TYPE_BIT];
  assign w_y    = instruction[A_BIT] ? inM : r_a;

  hack_alu u_alu (
    .i_x   (r_d),
    .i_y   (w_y),
    .i_zx  (instruction[ZX_BIT]),
    .i_nx  (instruction[NX_BIT]),
    .i_zy  (instruction[ZY_BIT]),
    .i_ny  (instruction[NY_BIT]),
    .i_f   (instruction[F_BIT]),
    .i_no  (instruction[NO_BIT]),
    .o_out (w_alu_out),
    .o_zr  (w_zr),
    .o_ng  (w_ng)
  );

  // Jump and register-load enables are only meaningful for C-instructions.
  assign w_jump = w_is_c & ((instruction[JLT_BIT] & w_ng) |
                            (instruction[JEQ_BIT] & w_zr) |
                            (instruction[JGT_BIT] & ~w_zr & ~w_ng));
  assign w_load_a = ~w_is_c | instruction[DEST_A_BIT];
  assign w_load_d = w_is_c & instruction[DEST_D_BIT];

  assign outM     = w_alu_out;
  assign writeM   = w_is_c & instruction[DEST_M_BIT] & ~reset;
  assign addressM = r_a[ADDR_W-1:0];
  assign pc       = r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
    end else if (w_load_a) begin
      r_a <= w_is_c ? w_alu_out : {1'b0, instruction[ADDR_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
    end else if (w_load_d) begin
      r_d <= w_alu_out;
    end
  end

  // Jump target is the A value before this edge, even when dA also loads A.
  // The increment wraps 0x7FFF -> 0x0000 by width truncation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_jump) begin
      r_pc <= r_a[ADDR_W-1:0];
    end else begin
      r_pc <= r_pc + 15'd1;
    end
  end

endmodule
